// File: rtl/ahb_default_slave.sv
// AHB default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.
// Optional debug capture of the first failing transfer is built when AHB_DEFSLV_ERR_LOG_EN is defined.

package AHB_package;
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_type;
endpackage

module ahb_default_slave
  import AHB_package::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hwrite,
  input  logic                      hready,
  output logic                      hreadyout,
  output logic [1:0]                hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  input  logic                      err_clr,
  output logic                      err_valid,
  output logic [AHB_ADDR_WIDTH-1:0] err_addr,
  output logic                      err_write,
  output logic [ERR_CNT_WIDTH-1:0]  err_count
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t     state_q, state_d;
  logic       accept;
  logic       hreadyout_q, hreadyout_d;
  logic [1:0] hresp_q, hresp_d;

  // The state register samples accept at the address-phase edge, so the data phase
  // that follows is already ST_ERR1; outputs are registered from the next state.
  always_comb begin
    accept  = hsel && hready && (htrans == TRANS_NONSEQ || htrans == TRANS_SEQ);
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = accept ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    hreadyout_d = (state_d != ST_ERR1);
    hresp_d     = (state_d == ST_IDLE) ? RESP_OKAY : RESP_ERROR;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = '0;

`ifdef AHB_DEFSLV_ERR_LOG_EN
  logic                      err_valid_q, err_valid_d;
  logic [AHB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                      err_write_q, err_write_d;
  logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // err_clr is applied before the capture so a coinciding error starts a fresh log.
  always_comb begin
    err_valid_d = err_clr ? 1'b0 : err_valid_q;
    err_addr_d  = err_clr ? '0   : err_addr_q;
    err_write_d = err_clr ? 1'b0 : err_write_q;
    err_count_d = err_clr ? '0   : err_count_q;
    if (accept) begin
      if (!err_valid_d) begin
        err_valid_d = 1'b1;
        err_addr_d  = haddr;
        err_write_d = hwrite;
      end
      err_count_d = sat_inc(err_count_d);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_write = err_write_q;
  assign err_count = err_count_q;
`else
  logic unused_log_inputs;
  assign unused_log_inputs = ^{err_clr, haddr, hwrite};

  assign err_valid = 1'b0;
  assign err_addr  = '0;
  assign err_write = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ahb_default_slave.sv
// Directed bench for ahb_default_slave: an 8-bit and a 2-bit error-counter instance share one stimulus.
// Expected capture values follow AHB_DEFSLV_ERR_LOG_EN; with it undefined they are all zero.

module tb_ahb_default_slave;
  import AHB_package::*;

`ifdef AHB_DEFSLV_ERR_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  htrans_type  htrans;
  logic        hwrite;
  logic        hready;
  logic        err_clr;

  logic        hreadyout, hreadyout_w2;
  logic [1:0]  hresp, hresp_w2;
  logic [31:0] hrdata, hrdata_w2;
  logic        err_valid, err_valid_w2;
  logic [31:0] err_addr, err_addr_w2;
  logic        err_write, err_write_w2;
  logic [7:0]  err_count;
  logic [1:0]  err_count_w2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  ahb_default_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .ERR_CNT_WIDTH(8)) dut (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
    .hrdata(hrdata), .err_clr(err_clr), .err_valid(err_valid), .err_addr(err_addr),
    .err_write(err_write), .err_count(err_count)
  );

  ahb_default_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .ERR_CNT_WIDTH(2)) dut_w2 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hready(hready), .hreadyout(hreadyout_w2), .hresp(hresp_w2),
    .hrdata(hrdata_w2), .err_clr(err_clr), .err_valid(err_valid_w2), .err_addr(err_addr_w2),
    .err_write(err_write_w2), .err_count(err_count_w2)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_bus(input string tag, input logic rdy, input logic [1:0] resp);
    check({tag, ".hreadyout"}, hreadyout, rdy);
    check({tag, ".hresp"}, hresp, resp);
    check({tag, ".hreadyout_w2"}, hreadyout_w2, rdy);
    check({tag, ".hresp_w2"}, hresp_w2, resp);
  endtask

  task automatic check_log(input string tag, input logic vld, input logic [31:0] addr,
                           input logic wr, input int cnt8, input int cnt2);
    check({tag, ".err_valid"}, err_valid, LOG ? vld : 1'b0);
    check({tag, ".err_addr"}, err_addr, LOG ? addr : 32'h0);
    check({tag, ".err_write"}, err_write, LOG ? wr : 1'b0);
    check({tag, ".err_count"}, err_count, LOG ? cnt8 : 0);
    check({tag, ".err_count_w2"}, err_count_w2, LOG ? cnt2 : 0);
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = TRANS_IDLE;
    hready = 1'b1;
  endtask

  // One isolated erroring transfer: address phase, ERR1 (bus stalled), ERR2, back to OKAY.
  task automatic error_xfer(input string tag, input logic [31:0] addr, input logic wr);
    hsel = 1'b1; htrans = TRANS_NONSEQ; haddr = addr; hwrite = wr; hready = 1'b1;
    step();
    check_bus({tag, ".err1"}, 1'b0, 2'b01);
    bus_idle();
    hready = 1'b0;
    step();
    check_bus({tag, ".err2"}, 1'b1, 2'b01);
    hready = 1'b1;
    step();
    check_bus({tag, ".idle"}, 1'b1, 2'b00);
  endtask

  initial begin
    hreset = 1'b1; err_clr = 1'b0; haddr = '0; hwrite = 1'b0;
    bus_idle();
    step();
    step();
    check_bus("reset", 1'b1, 2'b00);
    check("reset.hrdata", hrdata, 32'h0);
    check_log("reset", 1'b0, 32'h0, 1'b0, 0, 0);

    // 1: single error at 0x7000
    hreset = 1'b0;
    error_xfer("t1", 32'h0000_7000, 1'b1);
    check("t1.hrdata", hrdata, 32'h0);
    check_log("t1", 1'b1, 32'h0000_7000, 1'b1, 1, 1);

    // 2: IDLE then BUSY while selected, with err_clr wiping the log
    hsel = 1'b1; htrans = TRANS_IDLE; haddr = 32'h0000_7100; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_bus("t2.idle", 1'b1, 2'b00);
    check_log("t2.clr", 1'b0, 32'h0, 1'b0, 0, 0);
    htrans = TRANS_BUSY;
    step();
    check_bus("t2.busy", 1'b1, 2'b00);
    bus_idle();
    step();
    check_bus("t2.after", 1'b1, 2'b00);
    check_log("t2", 1'b0, 32'h0, 1'b0, 0, 0);

    // 3: back-to-back errors, second address presented in ERR2
    hsel = 1'b1; htrans = TRANS_NONSEQ; haddr = 32'h0000_7000; hwrite = 1'b0; hready = 1'b1;
    step();
    check_bus("t3.err1a", 1'b0, 2'b01);
    haddr = 32'h0000_7004; hwrite = 1'b1; hready = 1'b0;
    step();
    check_bus("t3.err2a", 1'b1, 2'b01);
    hready = 1'b1;
    step();
    check_bus("t3.err1b", 1'b0, 2'b01);
    bus_idle();
    hready = 1'b0;
    step();
    check_bus("t3.err2b", 1'b1, 2'b01);
    hready = 1'b1;
    step();
    check_bus("t3.idle", 1'b1, 2'b00);
    check_log("t3", 1'b1, 32'h0000_7000, 1'b0, 2, 2);

    // 4: master cancels with IDLE in ERR2
    hsel = 1'b1; htrans = TRANS_NONSEQ; haddr = 32'h0000_7008; hready = 1'b1;
    step();
    check_bus("t4.err1", 1'b0, 2'b01);
    htrans = TRANS_IDLE; hready = 1'b0;
    step();
    check_bus("t4.err2", 1'b1, 2'b01);
    hready = 1'b1;
    step();
    check_bus("t4.cancel", 1'b1, 2'b00);
    step();
    check_bus("t4.stay", 1'b1, 2'b00);
    check_log("t4", 1'b1, 32'h0000_7000, 1'b0, 3, 3);

    // 5: reset during ERR1
    hsel = 1'b1; htrans = TRANS_SEQ; haddr = 32'h0000_700C; hready = 1'b1;
    step();
    check_bus("t5.err1", 1'b0, 2'b01);
    check_log("t5.pre", 1'b1, 32'h0000_7000, 1'b0, 4, 3);
    bus_idle();
    hready = 1'b0; hreset = 1'b1;
    step();
    hreset = 1'b0; hready = 1'b1;
    check_bus("t5.reset", 1'b1, 2'b00);
    check_log("t5", 1'b0, 32'h0, 1'b0, 0, 0);
    step();
    check_bus("t5.after", 1'b1, 2'b00);

    // 6: saturation on the 2-bit counter, then err_clr coinciding with a new error
    for (int i = 0; i < 5; i++) error_xfer("t6.loop", 32'h0000_8000 + 32'(i * 4), 1'b1);
    check_log("t6.sat", 1'b1, 32'h0000_8000, 1'b1, 5, 3);
    hsel = 1'b1; htrans = TRANS_NONSEQ; haddr = 32'h0000_9000; hwrite = 1'b0;
    hready = 1'b1; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_bus("t6.err1", 1'b0, 2'b01);
    check_log("t6.clrcap", 1'b1, 32'h0000_9000, 1'b0, 1, 1);
    bus_idle();
    hready = 1'b0;
    step();
    check_bus("t6.err2", 1'b1, 2'b01);
    hready = 1'b1;
    step();
    check_bus("t6.idle", 1'b1, 2'b00);
    check("t6.hrdata_w2", hrdata_w2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
